// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : median_pkg
//  Description : Shared types and constants for the median-filter sequencer.
//                Holds the FSM state enum, the tap count and the 3x3 window
//                offset tables. Tap t covers row offset DR[t], col offset DC[t].
//  Revision    : 1.0 - initial release
// ============================================================================
package median_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PROC  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int TAP_NUM = 9;

    // Tap index = (dr+1)*3 + (dc+1)
    localparam int DR [TAP_NUM] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    localparam int DC [TAP_NUM] = '{-1,  0,  1,-1, 0, 1,-1, 0, 1};

endpackage
`default_nettype wire

// File: rtl/median_tap_gen.sv
`default_nettype none
// ============================================================================
//  Module      : median_tap_gen
//  Description : Walks every output pixel in raster order and issues its nine
//                3x3 window taps, one per cycle, while en is high. Keeps the
//                pixel base address incrementally (no multiplier), flags taps
//                that fall outside the image, and produces registered tap
//                tags aligned with the 1-cycle RAM read data.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                clr          - synchronous clear of row/col/tap/base
//                en           - issue one tap this cycle
//                rd_en/rd_addr- RAM read strobe/address (held on padded taps)
//                tap_valid/tap_idx/tap_pad - tap tags, one cycle after issue
//                last_pix     - final tap of the final pixel is being issued
//  Revision    : 1.0 - initial release
// ============================================================================
module median_tap_gen
    import median_pkg::*;
#(
    parameter int WIDTH  = 410,
    parameter int DEPTH  = 361,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              tap_valid,
    output logic [3:0]        tap_idx,
    output logic              tap_pad,
    output logic              last_pix
);

    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [3:0]        r_tap;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_hold;
    logic              r_tap_valid;
    logic [3:0]        r_tap_idx;
    logic              r_tap_pad;

    int                w_dr;
    int                w_dc;
    logic [ADDR_W-1:0] w_addr;
    logic              w_pad;
    logic              w_last_tap;
    logic              w_last_col;
    logic              w_last_row;

    // Offset lookup through a compare loop keeps out-of-range tap codes harmless.
    always_comb begin
        w_dr = 0;
        w_dc = 0;
        for (int i = 0; i < TAP_NUM; i++) begin
            if (r_tap == 4'(i)) begin
                w_dr = DR[i];
                w_dc = DC[i];
            end
        end
    end

    // Row offsets are +/-WIDTH added to the running base; padding is detected
    // purely from edge position, so no row*WIDTH product is ever formed.
    always_comb begin
        w_addr = r_base;
        w_pad  = 1'b0;
        if (w_dr < 0) begin
            w_addr = w_addr - ADDR_W'(WIDTH);
            if (r_row == '0) w_pad = 1'b1;
        end else if (w_dr > 0) begin
            w_addr = w_addr + ADDR_W'(WIDTH);
            if (r_row == ADDR_W'(DEPTH-1)) w_pad = 1'b1;
        end
        if (w_dc < 0) begin
            w_addr = w_addr - 1'b1;
            if (r_col == '0) w_pad = 1'b1;
        end else if (w_dc > 0) begin
            w_addr = w_addr + 1'b1;
            if (r_col == ADDR_W'(WIDTH-1)) w_pad = 1'b1;
        end
    end

    assign w_last_tap = (r_tap == 4'(TAP_NUM-1));
    assign w_last_col = (r_col == ADDR_W'(WIDTH-1));
    assign w_last_row = (r_row == ADDR_W'(DEPTH-1));
    assign last_pix   = en & w_last_tap & w_last_col & w_last_row;

    assign rd_en   = en & ~w_pad;
    assign rd_addr = rd_en ? w_addr : r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '0;
            r_col  <= '0;
            r_tap  <= '0;
            r_base <= '0;
        end else if (clr) begin
            r_row  <= '0;
            r_col  <= '0;
            r_tap  <= '0;
            r_base <= '0;
        end else if (en) begin
            if (w_last_tap) begin
                r_tap <= '0;
                if (last_pix) begin
                    r_row  <= '0;
                    r_col  <= '0;
                    r_base <= '0;
                end else begin
                    // Raster order: the next pixel's base is always base+1,
                    // including the wrap onto the next row.
                    r_base <= r_base + 1'b1;
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end else begin
                r_tap <= r_tap + 1'b1;
            end
        end
    end

    // Padded taps leave the RAM address bus untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (rd_en) begin
            r_hold <= w_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap_valid <= 1'b0;
            r_tap_idx   <= '0;
            r_tap_pad   <= 1'b0;
        end else begin
            r_tap_valid <= en;
            r_tap_idx   <= en ? r_tap : 4'd0;
            r_tap_pad   <= en & w_pad;
        end
    end

    assign tap_valid = r_tap_valid;
    assign tap_idx   = r_tap_idx;
    assign tap_pad   = r_tap_pad;

endmodule
`default_nettype wire

// File: rtl/median_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : median_seq_ctrl
//  Description : Frame sequencer for the median-filter path. Loads a raster
//                pixel stream into the frame RAM, then issues all 3x3 window
//                reads to the median core, then waits for every result and
//                raises finish.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                start                 - begin a frame from IDLE or DONE
//                in_valid / in_ready   - source pixel handshake (LOAD only)
//                wr_en / wr_addr       - RAM write port
//                rd_en / rd_addr       - RAM read port
//                tap_valid/idx/pad     - tap tags aligned with RAM read data
//                med_valid             - median core result strobe
//                finish                - frame complete (level, in DONE)
//                proc_cycles           - PROC+DRAIN cycle count
//  Options     : MEDIAN_SEQ_PERF_EN    - build the proc_cycles counter;
//                                        otherwise proc_cycles is tied to 0
//  Revision    : 1.0 - initial release
// ============================================================================
module median_seq_ctrl
    import median_pkg::*;
#(
    parameter int WIDTH  = 410,
    parameter int DEPTH  = 361,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              tap_valid,
    output logic [3:0]        tap_idx,
    output logic              tap_pad,
    input  logic              med_valid,
    output logic              finish,
    output logic [31:0]       proc_cycles
);

    localparam int PIX_NUM = WIDTH * DEPTH;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_res_cnt;
    logic [ADDR_W:0]   w_res_nxt;
    logic              w_clr;
    logic              w_accept;
    logic              w_count;
    logic              w_proc;
    logic              w_last_pix;

    assign w_clr     = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_accept  = in_valid & (r_state == ST_LOAD);
    assign w_proc    = (r_state == ST_PROC);
    assign w_count   = med_valid & ((r_state == ST_PROC) | (r_state == ST_DRAIN));
    assign w_res_nxt = r_res_cnt + {{ADDR_W{1'b0}}, w_count};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        wr_en       = 1'b0;
        finish      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
                if (w_accept && (r_wr_addr == ADDR_W'(PIX_NUM-1))) w_state_nxt = ST_PROC;
            end
            ST_PROC: begin
                if (w_last_pix) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Includes this cycle's strobe so finish follows the last
                // result by exactly one cycle.
                if (w_res_nxt >= (ADDR_W+1)'(PIX_NUM)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                finish = 1'b1;
                if (start) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_res_cnt <= '0;
        end else if (w_clr) begin
            r_wr_addr <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_accept) r_wr_addr <= r_wr_addr + 1'b1;
            if (w_count)  r_res_cnt <= w_res_nxt;
        end
    end

    assign wr_addr = r_wr_addr;

    median_tap_gen #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_tap_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_clr),
        .en        (w_proc),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .tap_valid (tap_valid),
        .tap_idx   (tap_idx),
        .tap_pad   (tap_pad),
        .last_pix  (w_last_pix)
    );

`ifdef MEDIAN_SEQ_PERF_EN
    logic [31:0] r_proc_cycles;

    // Counts every PROC and DRAIN cycle, so it stops on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proc_cycles <= '0;
        end else if (w_clr) begin
            r_proc_cycles <= '0;
        end else if ((r_state == ST_PROC) || (r_state == ST_DRAIN)) begin
            r_proc_cycles <= r_proc_cycles + 32'd1;
        end
    end

    assign proc_cycles = r_proc_cycles;
`else
    assign proc_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_median_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_median_seq_ctrl
//  Description : Self-checking bench for median_seq_ctrl on a 4x3 image with
//                a 1-cycle-latency RAM model. Expected taps, addresses, pads,
//                finish timing and proc_cycles come from window arithmetic
//                on (row, col, dr, dc) and from the bench's own med_valid
//                schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_median_seq_ctrl;

    localparam int W        = 4;
    localparam int D        = 3;
    localparam int AW       = 4;
    localparam int N        = W * D;
    localparam int PROC_LEN = 9 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          med_valid = 1'b0;
    logic          in_ready, wr_en, rd_en, tap_valid, tap_pad, finish;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [3:0]    tap_idx;
    logic [31:0]   proc_cycles;

    logic [7:0]    pix = 8'd0;
    logic [7:0]    mem [0:(1<<AW)-1];
    logic [7:0]    ram_q = 8'd0;
    int            img [N];
    int            last_rd = 0;

    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    median_seq_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .tap_valid   (tap_valid),
        .tap_idx     (tap_idx),
        .tap_pad     (tap_pad),
        .med_valid   (med_valid),
        .finish      (finish),
        .proc_cycles (proc_cycles)
    );

    // Frame RAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= pix;
        if (rd_en) ram_q <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Window geometry of issue slot k within PROC.
    function automatic bit k_pad(input int k);
        int p, t, r, c, dr, dc;
        p = k / 9; t = k % 9; r = p / W; c = p % W;
        dr = t / 3 - 1; dc = t % 3 - 1;
        return (r + dr < 0) || (r + dr >= D) || (c + dc < 0) || (c + dc >= W);
    endfunction

    function automatic int k_addr(input int k);
        int p, t, r, c, dr, dc;
        p = k / 9; t = k % 9; r = p / W; c = p % W;
        dr = t / 3 - 1; dc = t % 3 - 1;
        return (r + dr) * W + (c + dc);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,    0);
        check({tag, "_wr_en"},     wr_en,       0);
        check({tag, "_wr_addr"},   wr_addr,     0);
        check({tag, "_rd_en"},     rd_en,       0);
        check({tag, "_rd_addr"},   rd_addr,     0);
        check({tag, "_tap_valid"}, tap_valid,   0);
        check({tag, "_tap_idx"},   tap_idx,     0);
        check({tag, "_tap_pad"},   tap_pad,     0);
        check({tag, "_finish"},    finish,      0);
        check({tag, "_proc_cyc"},  proc_cycles, 0);
    endtask

    // mode 0: result 4 cycles after each pixel's last tap data
    // mode 1: result with the last tap data, final result 3 cycles late
    // mode 2: 12 results at random cycles inside PROC
    // abort_k >= 0: assert reset asynchronously at PROC slot abort_k
    task automatic run_frame(input int mode, input int abort_k, input bit was_done);
        int  beats, proc_start, done_c, last_med, k, s, exp_pc;
        bit  loading, p, completed, is_med;
        int  med_at [N];
        bit  sel [PROC_LEN];
        beats = 0; proc_start = -1; done_c = -1; last_med = -1; completed = 0;
        foreach (sel[i]) sel[i] = 1'b0;

        @(negedge clk);
        start = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        med_valid = 1'($urandom_range(0, 1));
        #1;
        check("finish_pre",   finish,   was_done);
        check("in_ready_pre", in_ready, 0);
        check("wr_en_pre",    wr_en,    0);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            loading = (proc_start < 0);
            pix = 8'($urandom);
            if (loading) in_valid = (c > 40) ? 1'b1 : ($urandom_range(0, 9) < 7);
            else         in_valid = 1'($urandom_range(0, 1));
            start = (loading || c < done_c - 1) ? ($urandom_range(0, 5) == 0) : 1'b0;
            is_med = 1'b0;
            if (!loading) foreach (med_at[i]) if (med_at[i] == c) is_med = 1'b1;
            if (loading || c >= done_c) med_valid = 1'($urandom_range(0, 1));
            else                        med_valid = is_med;
            #1;

            check("in_ready", in_ready, loading);
            check("wr_en",    wr_en,    loading && in_valid);
            if (loading && in_valid) begin
                check("wr_addr", wr_addr, beats);
                img[beats] = pix;
                beats++;
                if (beats == N) begin
                    proc_start = c + 1;
                    for (int i = 0; i < N; i++) begin
                        if (mode == 0) med_at[i] = proc_start + 9 * i + 9 + 4;
                        else if (mode == 1) med_at[i] = proc_start + 9 * i + 9 + ((i == N - 1) ? 3 : 0);
                        else begin
                            do s = $urandom_range(0, PROC_LEN - 1); while (sel[s]);
                            sel[s] = 1'b1;
                            med_at[i] = proc_start + s;
                        end
                        if (med_at[i] > last_med) last_med = med_at[i];
                    end
                    done_c = ((proc_start + PROC_LEN > last_med) ? proc_start + PROC_LEN : last_med) + 1;
                end
            end

            k = (proc_start >= 0) ? c - proc_start : -1000;
            if (k >= 0 && k < PROC_LEN) begin
                p = k_pad(k);
                check("rd_en", rd_en, !p);
                if (p) check("rd_addr_hold", rd_addr, last_rd);
                else begin
                    check("rd_addr", rd_addr, k_addr(k));
                    last_rd = k_addr(k);
                end
            end else begin
                check("rd_en_idle", rd_en, 0);
            end

            if (k >= 1 && k <= PROC_LEN) begin
                p = k_pad(k - 1);
                check("tap_valid", tap_valid, 1);
                check("tap_idx",   tap_idx,   (k - 1) % 9);
                check("tap_pad",   tap_pad,   p);
                if (!p) check("tap_data", ram_q, img[k_addr(k - 1)]);
            end else begin
                check("tap_valid_idle", tap_valid, 0);
            end

            check("finish", finish, (done_c >= 0) && (c >= done_c));
`ifdef MEDIAN_SEQ_PERF_EN
            exp_pc = (k < 0) ? 0 : ((c < done_c) ? k : done_c - proc_start);
`else
            exp_pc = 0;
`endif
            check("proc_cycles", proc_cycles, exp_pc);

            if (abort_k >= 0 && k == abort_k) begin
                #2 rst_n = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                last_rd = 0;
                @(negedge clk);
                start = 1'b0; in_valid = 1'b0; med_valid = 1'b0;
                rst_n = 1'b1;
                completed = 1'b1;
                break;
            end
            if (done_c >= 0 && c >= done_c + 3) begin
                completed = 1'b1;
                break;
            end
        end
        if (!completed) check("frame_timeout", 0, 1);
        start = 1'b0;
    endtask

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores in_valid and med_valid until start.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            med_valid = 1'($urandom_range(0, 1));
            #1;
            check("idle_in_ready", in_ready, 0);
            check("idle_wr_en",    wr_en,    0);
            check("idle_finish",   finish,   0);
        end

        run_frame(0, -1, 1'b0);
        run_frame(1, -1, 1'b1);
        run_frame(2, -1, 1'b1);
        run_frame(2, 40, 1'b1);

        // After an abort there is no resume: stays idle without start.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            check("post_rst_in_ready", in_ready, 0);
            check("post_rst_finish",   finish,   0);
            check("post_rst_rd_en",    rd_en,    0);
        end

        run_frame(0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/median_seq_ctrl.md
Name: median_seq_ctrl

Overview:
Sequencer for the median-filter image path. Handles three jobs:
- Load phase: accepts a raster pixel stream and generates frame-buffer write addresses.
- Process phase: walks every output pixel and issues the nine 3x3 window reads (zero-padded at image borders) to the median core.
- Drain phase: counts median results and raises finish.

Sits between the pixel source, the single-port frame RAM (1-cycle read latency) and the median core.

Parameters:
WIDTH, 410, image columns
DEPTH, 361, image rows
ADDR_W, 18, RAM address width; 2^ADDR_W >= WIDTH*DEPTH is required

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse; begins a frame from IDLE or DONE
in_valid  in  1  pixel present on source stream
in_ready  out  1  high only in LOAD
wr_en  out  1  RAM write strobe (= in_valid & in_ready)
wr_addr  out  ADDR_W  RAM write address
rd_en  out  1  RAM read strobe, low for padded taps
rd_addr  out  ADDR_W  RAM read address
tap_valid  out  1  window tap present on RAM data, aligned with RAM read data (1 cycle after issue)
tap_idx  out  4  tap number 0..8, aligned with tap_valid
tap_pad  out  1  tap is outside the image; core uses 0; aligned with tap_valid
med_valid  in  1  median core result strobe
finish  out  1  frame complete
proc_cycles  out  32  optional performance count

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- State on reset: state=IDLE; all counters 0.
- Outputs on reset: all outputs 0 except in_ready=0 and finish=0. Reset mid-frame aborts immediately; there is no resume.
- States: IDLE, LOAD, PROC, DRAIN, DONE.
- IDLE: start -> LOAD. wr_addr is cleared to 0.
- LOAD:
  - in_ready=1.
  - Each accepted beat: wr_en=1 and wr_addr increments by 1 on the following cycle.
  - Accepting the beat at wr_addr=WIDTH*DEPTH-1 -> PROC on the next cycle.
  - in_valid low stalls LOAD indefinitely.
- PROC:
  - Counters row, col and tap (0..8). Exactly one tap per cycle, so each pixel takes 9 cycles.
  - Tap order: tap=(dr+1)*3+(dc+1) with dr,dc in {-1,0,1}.
  - Tap address = base + dr*WIDTH + dc, where base=row*WIDTH+col is maintained incrementally (no multiplier).
  - pad = (row+dr) outside 0..DEPTH-1, or (col+dc) outside 0..WIDTH-1.
  - Padded tap: rd_en=0 and rd_addr holds its previous value.
  - After tap 8: col increments; on the last col it wraps to 0 and row increments.
  - After tap 8 of pixel (DEPTH-1, WIDTH-1) -> DRAIN.
  - PROC duration is exactly 9*WIDTH*DEPTH cycles.
- Tap outputs: tap_valid, tap_idx and tap_pad are registered copies of the issue-cycle values, so they trail rd_* by one cycle.
- Result counting:
  - med_valid is counted in PROC and DRAIN.
  - DRAIN -> DONE when the result count reaches WIDTH*DEPTH. If that count is already reached on PROC exit, DRAIN lasts 1 cycle.
  - med_valid in IDLE, LOAD or DONE is ignored.
- DONE: finish=1 (level). start -> LOAD clears finish, wr_addr and all counters.
- start is ignored in LOAD, PROC and DRAIN. in_valid is ignored outside LOAD.
- Simultaneous start and reset: reset wins.

Optional Feature:
- Macro: MEDIAN_SEQ_PERF_EN.
- Defined: proc_cycles counts clk cycles from PROC entry to DONE entry. It freezes in DONE and clears on start.
- Undefined: proc_cycles is constant 0 and no counter logic is built.

Decomposition:
- Package median_pkg holds:
  - the state enum (IDLE/LOAD/PROC/DRAIN/DONE);
  - TAP_NUM=9;
  - the tap offset tables DR[9] and DC[9].
- Natural sub-module: median_tap_gen. It owns row/col/tap/base, and generates pad and rd_addr and the last-pixel flag. The top level keeps the FSM, the load counter and the drain counter.

Test Plan:
Bench uses WIDTH=4, DEPTH=3, ADDR_W=4, and a RAM model with 1-cycle read latency.
1. Reset values: assert rst_n=0 mid-PROC -> state IDLE, all outputs 0, finish=0 within the same cycle (asynchronous).
2. Load: 12 beats with in_valid gaps -> wr_addr goes 0..11 only on accepted beats. PROC entered on the cycle after beat 11. in_ready=0 afterwards.
3. Corner pixel (0,0): taps 0,1,2,3,6 are padded (rd_en=0). Taps 4,5,7,8 read addresses 0,1,4,5.
4. Interior and last pixels:
   - Pixel (1,2): taps 0..8 read addresses 1,2,3,5,6,7,9,10,11 with no pads.
   - Pixel (2,3): taps 0,1,3,4 read 6,7,10,11; taps 2,5,6,7,8 padded.
5. Drain and finish:
   - PROC lasts exactly 108 cycles.
   - Feed med_valid with 4-cycle latency -> finish rises on the cycle after the 12th med_valid.
   - start in DONE restarts LOAD with wr_addr=0.
6. With MEDIAN_SEQ_PERF_EN and 3 extra stall cycles before the final med_valid -> proc_cycles=112 in DONE. Without the macro -> 0.
